// File: rtl/multiply_pipe.sv
// Lock-step LANES-wide signed multiplier, elastic STAGES-deep pipe, optional round/shift by FRAC.
// Latency: STAGES cycles accept-to-vld_out. Backpressure: per-stage bubble collapse, rdy_out is combinational from rdy_in.
// MULTIPLY_PIPE_SAT_EN: saturate instead of wrap and add the sat_flag port.
`ifndef INTEGER_WIDTH
`define INTEGER_WIDTH 8
`endif

module multiply_pipe #(
  parameter int W_IN   = `INTEGER_WIDTH,
  parameter int W_OUT  = 2*W_IN,
  parameter int LANES  = 4,
  parameter int STAGES = 2,
  parameter int FRAC   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vld_in,
  output logic                     rdy_out,
  input  logic [LANES*W_IN-1:0]    a_in,
  input  logic [LANES*W_IN-1:0]    b_in,
  output logic                     vld_out,
  input  logic                     rdy_in,
  output logic [LANES*W_OUT-1:0]   product
`ifdef MULTIPLY_PIPE_SAT_EN
  ,
  output logic [LANES-1:0]         sat_flag
`endif
);

  localparam int PW = 2*W_IN;
  localparam int RW = PW + 1;
  localparam int XW = (W_OUT > RW) ? W_OUT : RW;
  localparam logic signed [RW-1:0] RND = RW'((RW'(1) << FRAC) >> 1);
`ifdef MULTIPLY_PIPE_SAT_EN
  localparam logic signed [XW-1:0] SMAX = $signed((XW'(1) << (W_OUT-1)) - XW'(1));
  localparam logic signed [XW-1:0] SMIN = ~SMAX;
`endif

  logic [STAGES:1]        valid_q;
  logic [STAGES:0]        up_v;
  logic [STAGES:1]        rdy;
  logic [LANES*W_IN-1:0]  op_a;
  logic [LANES*W_IN-1:0]  op_b;
  logic [LANES*PW-1:0]    full_prod;
  logic [LANES*PW-1:0]    last_prod;

  // up_v[s-1] is the valid feeding stage s; the top bit is the output valid.
  assign up_v    = {valid_q, vld_in};
  assign vld_out = up_v[STAGES];
  assign rdy_out = rdy[1];

  // Stage s can move unless it and every stage after it are full while rdy_in is low.
  always_comb begin
    logic all_v;
    rdy   = '0;
    all_v = 1'b1;
    for (int s = 1; s <= STAGES; s++) begin
      all_v = 1'b1;
      for (int k = s; k <= STAGES; k++) begin
        all_v = all_v & valid_q[k];
      end
      rdy[s] = rdy_in | ~all_v;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      op_a    <= '0;
      op_b    <= '0;
    end else begin
      for (int s = 1; s <= STAGES; s++) begin
        if (rdy[s]) valid_q[s] <= up_v[s-1];
      end
      if (vld_in && rdy[1]) begin
        op_a <= a_in;
        op_b <= b_in;
      end
    end
  end

  always_comb begin
    full_prod = '0;
    for (int i = 0; i < LANES; i++) begin
      full_prod[i*PW +: PW] = PW'($signed(op_a[i*W_IN +: W_IN])) *
                              PW'($signed(op_b[i*W_IN +: W_IN]));
    end
  end

  generate
    if (STAGES == 1) begin : g_single
      assign last_prod = full_prod;
    end else begin : g_deep
      logic [LANES*PW-1:0] prod_q [2:STAGES];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 2; s <= STAGES; s++) prod_q[s] <= '0;
        end else begin
          if (valid_q[1] && rdy[2]) prod_q[2] <= full_prod;
          for (int s = 3; s <= STAGES; s++) begin
            if (valid_q[s-1] && rdy[s]) prod_q[s] <= prod_q[s-1];
          end
        end
      end

      assign last_prod = prod_q[STAGES];
    end
  endgenerate

  // Extra headroom bit keeps the rounding add from overflowing the full product.
  always_comb begin
    logic signed [PW-1:0] p_l;
    logic signed [RW-1:0] sum;
    logic signed [RW-1:0] sh;
`ifdef MULTIPLY_PIPE_SAT_EN
    logic signed [XW-1:0] rx;
    rx       = '0;
    sat_flag = '0;
`endif
    product = '0;
    p_l     = '0;
    sum     = '0;
    sh      = '0;
    for (int i = 0; i < LANES; i++) begin
      p_l = $signed(last_prod[i*PW +: PW]);
      sum = RW'(p_l) + RND;
      sh  = sum >>> FRAC;
`ifdef MULTIPLY_PIPE_SAT_EN
      rx = XW'(sh);
      if (rx > SMAX) begin
        product[i*W_OUT +: W_OUT] = SMAX[W_OUT-1:0];
        sat_flag[i]               = vld_out;
      end else if (rx < SMIN) begin
        product[i*W_OUT +: W_OUT] = SMIN[W_OUT-1:0];
        sat_flag[i]               = vld_out;
      end else begin
        product[i*W_OUT +: W_OUT] = W_OUT'(rx);
      end
`else
      product[i*W_OUT +: W_OUT] = W_OUT'(sh);
`endif
    end
  end

endmodule

// File: tb/tb_multiply_pipe.sv
// Scoreboard bench for multiply_pipe: three configurations (plain, FRAC=4, narrow W_OUT=8), all STAGES=3, LANES=2.
`timescale 1ns/1ps

module tb_multiply_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        vld_i [3];
  logic        rdy_i [3];
  logic [15:0] a_i   [3];
  logic [15:0] b_i   [3];

  logic vo0, vo1, vo2, ro0, ro1, ro2;
  logic [31:0] p0, p1;
  logic [15:0] p2;
  logic [1:0]  sf0, sf1, sf2;

  multiply_pipe #(.W_IN(8), .W_OUT(16), .LANES(2), .STAGES(3), .FRAC(0)) u0 (
    .clk(clk), .rst(rst), .vld_in(vld_i[0]), .rdy_out(ro0), .a_in(a_i[0]), .b_in(b_i[0]),
    .vld_out(vo0), .rdy_in(rdy_i[0]), .product(p0)
`ifdef MULTIPLY_PIPE_SAT_EN
    , .sat_flag(sf0)
`endif
  );

  multiply_pipe #(.W_IN(8), .W_OUT(16), .LANES(2), .STAGES(3), .FRAC(4)) u1 (
    .clk(clk), .rst(rst), .vld_in(vld_i[1]), .rdy_out(ro1), .a_in(a_i[1]), .b_in(b_i[1]),
    .vld_out(vo1), .rdy_in(rdy_i[1]), .product(p1)
`ifdef MULTIPLY_PIPE_SAT_EN
    , .sat_flag(sf1)
`endif
  );

  multiply_pipe #(.W_IN(8), .W_OUT(8), .LANES(2), .STAGES(3), .FRAC(0)) u2 (
    .clk(clk), .rst(rst), .vld_in(vld_i[2]), .rdy_out(ro2), .a_in(a_i[2]), .b_in(b_i[2]),
    .vld_out(vo2), .rdy_in(rdy_i[2]), .product(p2)
`ifdef MULTIPLY_PIPE_SAT_EN
    , .sat_flag(sf2)
`endif
  );

`ifndef MULTIPLY_PIPE_SAT_EN
  assign sf0 = 2'b00;
  assign sf1 = 2'b00;
  assign sf2 = 2'b00;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard entries: {sat flags[1:0], packed product[31:0]}
  logic [33:0] q0 [$];
  logic [33:0] q1 [$];
  logic [33:0] q2 [$];

  function automatic void sb_push(input int d, input logic [33:0] e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic int sb_size(input int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [33:0] sb_pop(input int d);
    case (d)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic logic rdy_of(input int d);
    case (d)
      0: return ro0;
      1: return ro1;
      default: return ro2;
    endcase
  endfunction

  // Reference arithmetic for one lane, result masked to the lane width.
  function automatic logic [15:0] model_lane(input int d, input int a, input int b, output logic clip);
    longint p, r, mx, mn;
    int frac, wout;
    frac = (d == 1) ? 4 : 0;
    wout = (d == 2) ? 8 : 16;
    p = longint'(a) * longint'(b);
    if (frac > 0) r = (p + (longint'(1) <<< (frac - 1))) >>> frac;
    else          r = p;
    mx = (longint'(1) <<< (wout - 1)) - 1;
    mn = -mx - 1;
    clip = 1'b0;
`ifdef MULTIPLY_PIPE_SAT_EN
    if (r > mx) begin r = mx; clip = 1'b1; end
    else if (r < mn) begin r = mn; clip = 1'b1; end
`endif
    return 16'(r & ((longint'(1) <<< wout) - 1));
  endfunction

  function automatic logic [33:0] expect_beat(input int d, input int a0, input int b0, input int a1, input int b1);
    logic [15:0] l0, l1;
    logic c0, c1;
    int wout;
    wout = (d == 2) ? 8 : 16;
    l0 = model_lane(d, a0, b0, c0);
    l1 = model_lane(d, a1, b1, c1);
    return {c1, c0, 32'(l0) | (32'(l1) << wout)};
  endfunction

  int          n_acc     [3];
  int          last_acc  [3];
  int          retries   [3];
  int          n_out     [3];
  int          out_cyc   [3];
  logic [31:0] last_prod [3];

  task automatic send(input int d, input int a0, input int b0, input int a1, input int b1);
    logic [33:0] e;
    e = expect_beat(d, a0, b0, a1, b1);
    a_i[d]   = {a1[7:0], a0[7:0]};
    b_i[d]   = {b1[7:0], b0[7:0]};
    vld_i[d] = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (rdy_of(d)) begin
        sb_push(d, e);
        last_acc[d] = cyc;
        n_acc[d]++;
        @(posedge clk);
        #1;
        return;
      end
      retries[d]++;
      @(posedge clk);
      #1;
    end
    check($sformatf("send%0d_timeout", d), 64'(rdy_of(d)), 64'(1));
  endtask

  task automatic idle(input int d);
    vld_i[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int t;
    t = 0;
    while (sb_size(d) != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    if (sb_size(d) != 0) check($sformatf("drain%0d_timeout", d), 64'(sb_size(d)), 64'(0));
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic mon(input int d, input logic v, input logic r, input logic [31:0] p, input logic [1:0] sf);
    logic [33:0] e;
    if (v && r) begin
      n_out[d]++;
      out_cyc[d]   = cyc;
      last_prod[d] = p;
      if (sb_size(d) == 0) begin
        check($sformatf("u%0d_spurious", d), 64'(v), 64'(0));
      end else begin
        e = sb_pop(d);
        check($sformatf("u%0d_prod", d), 64'(p), 64'(e[31:0]));
`ifdef MULTIPLY_PIPE_SAT_EN
        check($sformatf("u%0d_sat_flag", d), 64'(sf), 64'(e[33:32]));
`endif
      end
    end
  endtask

  logic        stall_seen = 1'b0;
  logic [31:0] stall_prod = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (stall_seen) begin
        check("stall_vld", 64'(vo0), 64'(1));
        check("stall_hold", 64'(p0), 64'(stall_prod));
      end
      stall_seen = vo0 && !rdy_i[0];
      stall_prod = p0;
      mon(0, vo0, rdy_i[0], p0, sf0);
      mon(1, vo1, rdy_i[1], p1, sf1);
      mon(2, vo2, rdy_i[2], {16'h0, p2}, sf2);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end

  initial begin
    int o, acc0;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      vld_i[d] = 1'b0;
      rdy_i[d] = 1'b1;
      a_i[d]   = '0;
      b_i[d]   = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_vld_out", 64'(vo0), 64'(0));
    check("rst_rdy_out", 64'(ro0), 64'(1));
    check("rst_product", 64'(p0), 64'(0));
    check("rst_product_u1", 64'(p1), 64'(0));
    @(posedge clk);
    #1;

    // Single beat, latency and one-cycle valid
    o = n_out[0];
    send(0, 7, -6, -128, -128);
    idle(0);
    drain(0);
    check("latency", 64'(out_cyc[0] - last_acc[0]), 64'(3));
    check("one_beat", 64'(n_out[0] - o), 64'(1));
    check("first_val", 64'(last_prod[0]), 64'(32'h4000_FFD6));

    // Back-to-back stream
    o = n_out[0];
    retries[0] = 0;
    for (int i = 0; i < 10; i++) send(0, i, i + 1, i, i + 1);
    idle(0);
    drain(0);
    check("stream_rdy_low", 64'(retries[0]), 64'(0));
    check("stream_count", 64'(n_out[0] - o), 64'(10));
    check("stream_last", 64'(last_prod[0]), 64'(32'h005A_005A));

    // Backpressure: fill, stall, drain
    o = n_out[0];
    acc0 = n_acc[0];
    rdy_i[0] = 1'b0;
    fork
      begin
        for (int k = 0; k < 5; k++) send(0, k + 20, 3, -k - 1, 5);
        idle(0);
      end
      begin
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("stall_accepted", 64'(n_acc[0] - acc0), 64'(3));
        check("stall_rdy_out", 64'(ro0), 64'(0));
        @(posedge clk);
        #1 rdy_i[0] = 1'b1;
      end
    join
    drain(0);
    check("stall_drained", 64'(n_out[0] - o), 64'(5));

    // Rounded fixed-point shift
    send(1, 3, 3, -3, 3);
    send(1, 8, 1, 8, 1);
    idle(1);
    drain(1);
    check("frac_last", 64'(last_prod[1]), 64'(32'h0001_0001));

    // Narrow output: wrap or saturate
    send(2, 100, 100, 100, 100);
    send(2, 127, -128, 127, -128);
    send(2, -128, -128, -128, -128);
    idle(2);
    drain(2);
`ifdef MULTIPLY_PIPE_SAT_EN
    check("narrow_last", 64'(last_prod[2]), 64'(32'h0000_7F7F));
`else
    check("narrow_last", 64'(last_prod[2]), 64'(32'h0000_0000));
`endif

    // Reset with two beats in flight
    o = n_out[0];
    send(0, 5, 5, 6, 6);
    send(0, 7, 7, 8, 8);
    idle(0);
    rst = 1'b1;
    rdy_i[0] = 1'b0;
    q0.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_vld_out", 64'(vo0), 64'(0));
    check("midrst_rdy_out", 64'(ro0), 64'(1));
    check("midrst_product", 64'(p0), 64'(0));
    @(posedge clk);
    #1 rdy_i[0] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_ghost", 64'(n_out[0] - o), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
